// File: rtl/seg_595_rx_decoder.sv
// seg_595_rx_decoder
// Listens to the 74HC595 pins (ds/shcp/stcp/oe) that drive the dynamic
// seven-segment display. It rebuilds each 14-bit storage word {seg[7:0], sel[5:0]}
// and turns it back into per-position hex digits, blank/minus/dp flags and
// frame status. Every pin is already in the sys_clk domain.
module seg_595_rx_decoder #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
    parameter logic [3:0]  WORD_BITS   = 4'd14
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        ds,
    input  logic        shcp,
    input  logic        stcp,
    input  logic        oe,
    output logic [23:0] digits,
    output logic [5:0]  blank,
    output logic [5:0]  minus,
    output logic [5:0]  dp,
    output logic [5:0]  seen,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        code_err,
    output logic        disp_on,
    output logic        stale
);

    // Result of decoding one active-low segment code. dp is forced off.
    typedef struct packed {
        logic       known;
        logic       is_blank;
        logic       is_minus;
        logic [3:0] value;
    } seg_dec_t;

    function automatic seg_dec_t decode_seg(input logic [6:0] segs);
        seg_dec_t r;
        r       = '0;
        r.known = 1'b1;
        case ({1'b1, segs})
            8'hC0: r.value = 4'h0;
            8'hF9: r.value = 4'h1;
            8'hA4: r.value = 4'h2;
            8'hB0: r.value = 4'h3;
            8'h99: r.value = 4'h4;
            8'h92: r.value = 4'h5;
            8'h82: r.value = 4'h6;
            8'hF8: r.value = 4'h7;
            8'h80: r.value = 4'h8;
            8'h90: r.value = 4'h9;
            8'h88: r.value = 4'hA;
            8'h83: r.value = 4'hB;
            8'hC6: r.value = 4'hC;
            8'hA1: r.value = 4'hD;
            8'h86: r.value = 4'hE;
            8'h8E: r.value = 4'hF;
            8'hFF: r.is_blank = 1'b1;
            8'hBF: r.is_minus = 1'b1;
            default: r.known = 1'b0;
        endcase
        return r;
    endfunction

    // Pin sampling. in_s1 holds {oe, stcp, shcp, ds}. edge_s2 holds {stcp, shcp}
    // one cycle older, and is used only for rise detection.
    logic [3:0]  in_s1_q, in_s1_d;
    logic [1:0]  edge_s2_q, edge_s2_d;

    logic [13:0] sr_q, sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic [23:0] digits_q, digits_d;
    logic [5:0]  blank_q, blank_d;
    logic [5:0]  minus_q, minus_d;
    logic [5:0]  dp_q, dp_d;
    logic [5:0]  seen_q, seen_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        code_err_q, code_err_d;
    logic        disp_on_q, disp_on_d;
    logic        stale_q, stale_d;

    logic        shcp_rise, stcp_rise;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        sel_onehot, word_ok, good_latch;
    logic [5:0]  seen_new;
    logic [23:0] tmo_last;
    seg_dec_t    dec;

    // The latch looks at sr_q, so it sees the word as it was before any shift in the same cycle.
    assign sel        = sr_q[5:0];
    assign seg        = sr_q[13:6];
    assign shcp_rise  = in_s1_q[1] & ~edge_s2_q[0];
    assign stcp_rise  = in_s1_q[2] & ~edge_s2_q[1];
    assign sel_onehot = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    assign word_ok    = (bit_cnt_q == WORD_BITS) && sel_onehot;
    assign good_latch = stcp_rise && word_ok;
    assign dec        = decode_seg(seg[6:0]);
    assign tmo_last   = TIMEOUT_CYC - 24'd1;

    // Next-state for the pin sampling stages.
    always_comb begin
        in_s1_d   = {oe, stcp, shcp, ds};
        edge_s2_d = in_s1_q[2:1];
    end

    // Next-state for the shifter, the latch decode and the timeout.
    always_comb begin
        // NOTE: every _d gets a hold/default value first, so no path can leave it unassigned (no latch).
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        digits_d      = digits_q;
        blank_d       = blank_q;
        minus_d       = minus_q;
        dp_d          = dp_q;
        seen_d        = seen_q;
        stale_d       = stale_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        code_err_d    = 1'b0;
        disp_on_d     = ~in_s1_q[3];
        seen_new      = seen_q | sel;

        if (shcp_rise) begin
            sr_d = {sr_q[12:0], in_s1_q[0]};
            if (bit_cnt_q != 4'hF) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end

        // A latch restarts the bit count. A shift in the same cycle counts as the first bit of the next word.
        if (stcp_rise) begin
            bit_cnt_d   = shcp_rise ? 4'd1 : 4'd0;
            frame_err_d = ~word_ok;
        end

        if (good_latch) begin
            tmo_cnt_d  = '0;
            stale_d    = 1'b0;
            code_err_d = ~dec.known;
            for (int i = 0; i < 6; i++) begin
                if (sel[i] && dec.known) begin
                    digits_d[4*i +: 4] = (dec.is_blank || dec.is_minus) ? 4'h0 : dec.value;
                    blank_d[i]         = dec.is_blank;
                    minus_d[i]         = dec.is_minus;
                    dp_d[i]            = ~seg[7];
                end
            end
            if (seen_new == 6'h3F) begin
                frame_valid_d = 1'b1;
                seen_d        = '0;
            end else begin
                seen_d = seen_new;
            end
        end else if (tmo_cnt_q != tmo_last) begin
            tmo_cnt_d = tmo_cnt_q + 24'd1;
        end else begin
            stale_d = 1'b1;
            seen_d  = '0;
        end
    end

    // Pin sampling flops. They keep tracking during reset, so releasing reset cannot create a false edge.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        in_s1_q   <= in_s1_d;
        edge_s2_q <= edge_s2_d;
    end

    // Decoder state with synchronous reset.
    always_ff @(posedge sys_clk) begin
        // NOTE: only registers with a defined power-up meaning are reset. The pin samplers above are not.
        if (sys_rst) begin
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            digits_q      <= '0;
            blank_q       <= 6'h3F;
            minus_q       <= '0;
            dp_q          <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            code_err_q    <= 1'b0;
            disp_on_q     <= 1'b0;
            stale_q       <= 1'b1;
        end else begin
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            digits_q      <= digits_d;
            blank_q       <= blank_d;
            minus_q       <= minus_d;
            dp_q          <= dp_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            code_err_q    <= code_err_d;
            disp_on_q     <= disp_on_d;
            stale_q       <= stale_d;
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign minus       = minus_q;
    assign dp          = dp_q;
    assign seen        = seen_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign code_err    = code_err_q;
    assign disp_on     = disp_on_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_595_rx_decoder.sv
// Directed bench for seg_595_rx_decoder. A table of 595 words carries the
// expected state after each latch. Hand-written sequences cover the
// simultaneous shift/latch case, the timeout and reset in the middle of a word.
module tb_seg_595_rx_decoder;

    logic        clk;
    logic        sys_rst;
    logic        ds, shcp, stcp, oe;
    logic [23:0] digits;
    logic [5:0]  blank, minus, dp, seen;
    logic        frame_valid, frame_err, code_err, disp_on, stale;

    int checks = 0;
    int errors = 0;

    seg_595_rx_decoder #(
        .TIMEOUT_CYC (24'd100),
        .WORD_BITS   (4'd14)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (sys_rst),
        .ds          (ds),
        .shcp        (shcp),
        .stcp        (stcp),
        .oe          (oe),
        .digits      (digits),
        .blank       (blank),
        .minus       (minus),
        .dp          (dp),
        .seen        (seen),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .code_err    (code_err),
        .disp_on     (disp_on),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] word;
        int          nbits;
        logic [23:0] digits;
        logic [5:0]  blank;
        logic [5:0]  minus;
        logic [5:0]  dp;
        logic [5:0]  seen;
        logic        fv;
        logic        fe;
        logic        ce;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send the low n bits of w, most significant bit first. Each bit gets one low and one high shcp cycle.
    task automatic send_bits(input logic [13:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ds   = w[i];
            shcp = 1'b0;
            tick();
            shcp = 1'b1;
            tick();
        end
    endtask

    // Raise stcp, capture the one-cycle status pulses, then drop stcp.
    task automatic latch(output logic fv, output logic fe, output logic ce);
        stcp = 1'b1;
        tick();
        tick();
        fv   = frame_valid;
        fe   = frame_err;
        ce   = code_err;
        stcp = 1'b0;
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_blank"},  32'(blank),  32'h3F);
        check({tag, "_minus"},  32'(minus),  32'h0);
        check({tag, "_dp"},     32'(dp),     32'h0);
        check({tag, "_seen"},   32'(seen),   32'h0);
        check({tag, "_pulses"}, 32'({frame_valid, frame_err, code_err}), 32'h0);
        check({tag, "_disp_on"}, 32'(disp_on), 32'h0);
        check({tag, "_stale"},  32'(stale),  32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fv, fe, ce;

        // Word = {seg, sel}. Expected columns give the outputs once each latch has been taken.
        vecs[0]  = '{{8'hC0, 6'h01}, 14, 24'h000000, 6'h3E, 6'h00, 6'h00, 6'h01, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{{8'hF9, 6'h01}, 14, 24'h000001, 6'h3E, 6'h00, 6'h00, 6'h01, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{{8'hA4, 6'h02}, 14, 24'h000021, 6'h3C, 6'h00, 6'h00, 6'h03, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{{8'hB0, 6'h04}, 14, 24'h000321, 6'h38, 6'h00, 6'h00, 6'h07, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{{8'h99, 6'h08}, 14, 24'h004321, 6'h30, 6'h00, 6'h00, 6'h0F, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{{8'h92, 6'h10}, 14, 24'h054321, 6'h20, 6'h00, 6'h00, 6'h1F, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{{8'h82, 6'h20}, 14, 24'h654321, 6'h00, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{{8'hC0, 6'h01}, 13, 24'h654321, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{{8'hC0, 6'h03}, 14, 24'h654321, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{{8'h7F, 6'h04}, 14, 24'h654021, 6'h04, 6'h00, 6'h04, 6'h04, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{{8'h00, 6'h04}, 14, 24'h654821, 6'h00, 6'h00, 6'h04, 6'h04, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{{8'hAA, 6'h04}, 14, 24'h654821, 6'h00, 6'h00, 6'h04, 6'h04, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{{8'hBF, 6'h01}, 14, 24'h654820, 6'h00, 6'h01, 6'h04, 6'h05, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{{8'hC0, 6'h00}, 14, 24'h654820, 6'h00, 6'h01, 6'h04, 6'h05, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{{8'h8E, 6'h08}, 14, 24'h65F820, 6'h00, 6'h01, 6'h04, 6'h0D, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{{8'h83, 6'h02}, 14, 24'h65F8B0, 6'h00, 6'h01, 6'h04, 6'h0F, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{{8'h06, 6'h10}, 14, 24'h6EF8B0, 6'h00, 6'h01, 6'h14, 6'h1F, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{{8'hA1, 6'h20}, 14, 24'hDEF8B0, 6'h00, 6'h01, 6'h14, 6'h00, 1'b1, 1'b0, 1'b0};

        sys_rst = 1'b1;
        ds      = 1'b0;
        shcp    = 1'b0;
        stcp    = 1'b0;
        oe      = 1'b1;
        repeat (3) tick();
        check_reset_state("rst");
        sys_rst = 1'b0;

        // disp_on is ~oe registered twice (sample stage + output stage).
        oe = 1'b0;
        tick();
        tick();
        check("disp_on", 32'(disp_on), 32'h1);

        for (int v = 0; v < 18; v++) begin
            send_bits(vecs[v].word, vecs[v].nbits);
            latch(fv, fe, ce);
            check($sformatf("v%0d_fv", v),     32'(fv),     32'(vecs[v].fv));
            check($sformatf("v%0d_fe", v),     32'(fe),     32'(vecs[v].fe));
            check($sformatf("v%0d_ce", v),     32'(ce),     32'(vecs[v].ce));
            check($sformatf("v%0d_digits", v), 32'(digits), 32'(vecs[v].digits));
            check($sformatf("v%0d_blank", v),  32'(blank),  32'(vecs[v].blank));
            check($sformatf("v%0d_minus", v),  32'(minus),  32'(vecs[v].minus));
            check($sformatf("v%0d_dp", v),     32'(dp),     32'(vecs[v].dp));
            check($sformatf("v%0d_seen", v),   32'(seen),   32'(vecs[v].seen));
            check($sformatf("v%0d_stale", v),  32'(stale),  32'h0);
            check($sformatf("v%0d_pulse_end", v), 32'({frame_valid, frame_err, code_err}), 32'h0);
        end

        // shcp and stcp rise in the same sample. The latch takes word A from before the shift.
        // That same shift is bit 1 of word B, so only 13 more bits are needed for B.
        begin
            logic [13:0] wa, wb;
            wa = {8'hF9, 6'h01};
            wb = {8'hA4, 6'h02};
            send_bits(wa, 14);
            shcp = 1'b0;
            ds   = wb[13];
            tick();
            shcp = 1'b1;
            stcp = 1'b1;
            tick();
            tick();
            check("cc_fe",     32'(frame_err), 32'h0);
            check("cc_digits", 32'(digits),    32'hDEF8B1);
            check("cc_minus",  32'(minus),     32'h00);
            check("cc_seen",   32'(seen),      32'h01);
            stcp = 1'b0;
            tick();
            send_bits(wb, 13);
            latch(fv, fe, ce);
            check("cc_next_fe",     32'(fe),     32'h0);
            check("cc_next_digits", 32'(digits), 32'hDEF821);
            check("cc_next_seen",   32'(seen),   32'h03);
        end

        // Timeout: the counter clears on the latch edge. stale rises exactly 100 cycles later.
        repeat (98) tick();
        check("tmo_before_stale", 32'(stale), 32'h0);
        check("tmo_before_seen",  32'(seen),  32'h03);
        tick();
        check("tmo_stale", 32'(stale), 32'h1);
        check("tmo_seen",  32'(seen),  32'h00);

        // The next good latch clears stale.
        send_bits({8'hC0, 6'h04}, 14);
        latch(fv, fe, ce);
        check("recover_stale",  32'(stale),  32'h0);
        check("recover_digits", 32'(digits), 32'hDEF021);
        check("recover_seen",   32'(seen),   32'h04);

        // Reset part-way through a word. The partial word and its bit count are discarded.
        send_bits({8'h99, 6'h08}, 7);
        sys_rst = 1'b1;
        tick();
        check_reset_state("midrst");
        sys_rst = 1'b0;
        send_bits({8'h92, 6'h10}, 14);
        latch(fv, fe, ce);
        check("post_rst_fe",     32'(fe),     32'h0);
        check("post_rst_digits", 32'(digits), 32'h050000);
        check("post_rst_blank",  32'(blank),  32'h2F);
        check("post_rst_seen",   32'(seen),   32'h10);
        check("post_rst_stale",  32'(stale),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
